imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream of the single-cycle core `xgriscv_sc`; replaces simulation-only `$readmemh` preload with a synthesizable load path.
- Accepts a byte stream (valid/ready), assembles little-endian 32-bit instruction words and writes them sequentially into instruction-memory RAM.
- Holds the core in reset (`cpu_rstn` low) until the image is complete, then releases it so the core fetches from its reset PC.

Parameters:
- `DEPTH_WORDS`, 1024, instruction RAM capacity in words; header counts above this are rejected.
- `WADDR_WIDTH`, 10, width of word-index write address; must satisfy 2^WADDR_WIDTH ≥ DEPTH_WORDS.
- `RELEASE_DELAY`, 2, clock edges from final accepted byte to core reset release; legal values ≥ 1.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `byte_valid`  in  1  upstream byte present
- `byte_data`  in  8  upstream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  one-cycle RAM write strobe
- `imem_waddr`  out  WADDR_WIDTH  word index being written (0-based)
- `imem_wdata`  out  32  assembled instruction word
- `cpu_rstn`  out  1  active-low reset to core; low while loading
- `load_done`  out  1  sticky, image loaded and core released
- `load_err`  out  1  sticky, header count exceeded DEPTH_WORDS
- `words_loaded`  out  WADDR_WIDTH+1  words written so far

Behaviour:
- Reset (async, `rstn`=0): state=HDR, byte-lane counter=0, `byte_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_rstn`=0, `load_done`=0, `load_err`=0, `words_loaded`=0. Asserting reset mid-load aborts and returns every output to these values; RAM contents already written are not cleared.
- Handshake: a byte transfers on a rising edge with `byte_valid`&`byte_ready`. `byte_ready`=1 only in HDR and DATA, is registered, and rises on the first edge after reset deasserts. Gaps in `byte_valid` stall without side effects.
- Stream format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte → bits[7:0]).
- HDR state:
  - Collect 4 bytes into N.
  - On the edge accepting the 4th byte: if N > DEPTH_WORDS, go to ERR. If N=0, go to RELEASE. Otherwise go to DATA.
- DATA state:
  - Bytes assemble into a shift register.
  - On the edge accepting byte 3 of a word, `imem_we`=1, `imem_wdata`=assembled word and `imem_waddr`=current index are registered. They are visible for exactly one cycle; `imem_we` returns to 0 next edge unless another word completes.
  - `words_loaded` increments on the same edge.
  - When the word completed is word N-1, go to RELEASE on that edge.
- RELEASE state:
  - `byte_ready`=0.
  - An internal counter guarantees `cpu_rstn` and `load_done` are registered high exactly RELEASE_DELAY edges after the edge that accepted the final byte (final header byte when N=0). State then becomes DONE.
- DONE state: `cpu_rstn`=1, `load_done`=1, `byte_ready`=0; further bytes are ignored (never accepted). Exit only by `rstn`.
- ERR state: `load_err`=1, `byte_ready`=0, `cpu_rstn`=0, no writes. Exit only by `rstn`.
- N=DEPTH_WORDS is legal; last `imem_waddr`=DEPTH_WORDS-1, no wrap.
- `load_done` and `load_err` are never both 1.

Test Plan:
- Reset values: hold `rstn`=0 for 3 cycles → all outputs 0, including `cpu_rstn`=0. First edge after release → `byte_ready`=1.
- Two-word load: send bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 back-to-back.
  - `imem_we` pulses with (waddr 0, wdata 0x00000013) and (waddr 1, wdata 0x00100093).
  - `words_loaded`=2.
  - `cpu_rstn`/`load_done` rise exactly 2 edges after the last byte edge.
- Empty image: header 00 00 00 00 → no `imem_we`; `cpu_rstn`=1 and `load_done`=1 two edges after the 4th header byte.
- Oversize: header count 1025 (01 04 00 00) → `load_err`=1, `byte_ready`=0, `cpu_rstn` stays 0, no writes; subsequent bytes are not accepted.
- Throttling: same two-word image with `byte_valid` low on alternate cycles → identical write sequence and values, only later in time; no extra `imem_we`.
- Mid-load reset: assert `rstn` after 2 bytes of word 1 → outputs return to reset values immediately. A full reload of a 1-word image (01 00 00 00, 73 00 10 00) → single write of 0x00100073 at waddr 0, then `load_done`=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream instruction-memory loader for the single-cycle core.
// Holds the core in reset until a length-prefixed image is written to RAM.
module imem_boot_loader #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int WADDR_WIDTH   = 10,
    parameter int RELEASE_DELAY = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [WADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_rstn,
    output logic                   load_done,
    output logic                   load_err,
    output logic [WADDR_WIDTH:0]   words_loaded
);

    localparam int RW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        RELEASE,
        DONE,
        ERR
    } state_t;

    state_t                 state;
    logic [1:0]             lane;
    logic [23:0]            sh;
    logic [WADDR_WIDTH:0]   n_words;
    logic [RW-1:0]          rel_cnt;
    logic                   xfer;
    logic [31:0]            full_word;

    assign xfer      = byte_valid & byte_ready;
    assign full_word = {byte_data, sh};

    // Loader FSM: header capture, word assembly/writes, delayed core release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= HDR;
            lane         <= 2'd0;
            sh           <= '0;
            n_words      <= '0;
            rel_cnt      <= '0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_rstn     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                HDR: begin
                    byte_ready <= 1'b1;
                    if (xfer) begin
                        sh   <= {byte_data, sh[23:8]};
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            if (full_word > 32'(DEPTH_WORDS)) begin
                                state      <= ERR;
                                byte_ready <= 1'b0;
                                load_err   <= 1'b1;
                            end else if (full_word == 32'd0) begin
                                state      <= RELEASE;
                                byte_ready <= 1'b0;
                                rel_cnt    <= RW'(RELEASE_DELAY - 1);
                            end else begin
                                state   <= DATA;
                                n_words <= full_word[WADDR_WIDTH:0];
                            end
                        end
                    end
                end
                DATA: begin
                    byte_ready <= 1'b1;
                    if (xfer) begin
                        sh   <= {byte_data, sh[23:8]};
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= full_word;
                            imem_waddr   <= words_loaded[WADDR_WIDTH-1:0];
                            words_loaded <= words_loaded + 1'b1;
                            if (words_loaded + 1'b1 == n_words) begin
                                state      <= RELEASE;
                                byte_ready <= 1'b0;
                                rel_cnt    <= RW'(RELEASE_DELAY - 1);
                            end
                        end
                    end
                end
                RELEASE: begin
                    byte_ready <= 1'b0;
                    if (rel_cnt == '0) begin
                        state     <= DONE;
                        cpu_rstn  <= 1'b1;
                        load_done <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end
                end
                DONE: begin
                    byte_ready <= 1'b0;
                    cpu_rstn   <= 1'b1;
                    load_done  <= 1'b1;
                end
                ERR: begin
                    byte_ready <= 1'b0;
                    cpu_rstn   <= 1'b0;
                    load_err   <= 1'b1;
                end
                default: begin
                    state      <= ERR;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Expected RAM writes go through a scoreboard queue checked by a monitor.
module tb_imem_boot_loader;

    localparam int AW = 10;

    logic          clk;
    logic          rstn;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [41:0] sb[$];

    imem_boot_loader dut (
        .clk          (clk),
        .rstn         (rstn),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_rstn     (cpu_rstn),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0)
                chk("write_addr_data", {imem_waddr, imem_wdata},
                    sb.pop_front());
        end
    end

    task automatic check_reset_vals(input string w);
        chk({w, "_ready"}, byte_ready, 0);
        chk({w, "_we"}, imem_we, 0);
        chk({w, "_waddr"}, imem_waddr, 0);
        chk({w, "_wdata"}, imem_wdata, 0);
        chk({w, "_cpu_rstn"}, cpu_rstn, 0);
        chk({w, "_done"}, load_done, 0);
        chk({w, "_err"}, load_err, 0);
        chk({w, "_words"}, words_loaded, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", byte_ready, 1);
    endtask

    // Present one byte from a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            chk("accept_timeout", byte_ready, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
    endtask

    // Called at the negedge right after the final-byte edge (or a gap cycle).
    task automatic check_release(input string w, input int already);
        if (already == 0) begin
            chk({w, "_rel_e0"}, cpu_rstn, 0);
            @(negedge clk);
        end
        chk({w, "_rel_e1"}, cpu_rstn, 0);
        chk({w, "_done_e1"}, load_done, 0);
        @(negedge clk);
        chk({w, "_rel_e2"}, cpu_rstn, 1);
        chk({w, "_done_e2"}, load_done, 1);
        chk({w, "_err_e2"}, load_err, 0);
        chk({w, "_ready_e2"}, byte_ready, 0);
    endtask

    logic [7:0] img2[$];
    logic [7:0] img1[$];

    initial begin
        rstn = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        img2 = '{8'h02, 8'h00, 8'h00, 8'h00,
                 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        img1 = '{8'h01, 8'h00, 8'h00, 8'h00,
                 8'h73, 8'h00, 8'h10, 8'h00};

        do_reset();

        // Two-word image back-to-back
        sb.push_back({10'd0, 32'h0000_0013});
        sb.push_back({10'd1, 32'h0010_0093});
        send_seq(img2, 1'b0);
        check_release("two", 0);
        chk("two_words", words_loaded, 2);
        chk("two_sb_empty", sb.size(), 0);
        byte_valid = 1'b1;
        byte_data = 8'h55;
        repeat (4) begin
            @(negedge clk);
            chk("done_ready_low", byte_ready, 0);
        end
        byte_valid = 1'b0;
        chk("done_words_hold", words_loaded, 2);

        // Empty image
        do_reset();
        send_seq('{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        check_release("empty", 0);
        chk("empty_words", words_loaded, 0);

        // Oversize header (1025)
        do_reset();
        send_seq('{8'h01, 8'h04, 8'h00, 8'h00}, 1'b0);
        chk("ovr_err", load_err, 1);
        chk("ovr_ready", byte_ready, 0);
        byte_valid = 1'b1;
        byte_data = 8'h13;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        chk("ovr_cpu_rstn", cpu_rstn, 0);
        chk("ovr_done", load_done, 0);
        chk("ovr_ready_hold", byte_ready, 0);
        chk("ovr_words", words_loaded, 0);

        // Throttled two-word image
        do_reset();
        sb.push_back({10'd0, 32'h0000_0013});
        sb.push_back({10'd1, 32'h0010_0093});
        send_seq(img2, 1'b1);
        check_release("thr", 1);
        chk("thr_words", words_loaded, 2);
        chk("thr_sb_empty", sb.size(), 0);

        // Mid-load reset then one-word reload
        do_reset();
        sb.push_back({10'd0, 32'h0000_0013});
        send_seq('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00}, 1'b0);
        chk("mid_words", words_loaded, 1);
        #1 rstn = 1'b0;
        #1;
        check_reset_vals("mid");
        chk("mid_sb_empty", sb.size(), 0);
        do_reset();
        sb.push_back({10'd0, 32'h0010_0073});
        send_seq(img1, 1'b0);
        check_release("reload", 0);
        chk("reload_words", words_loaded, 1);
        chk("reload_sb_empty", sb.size(), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
